// File: rtl/bit_cmd_gen.sv
// Push-button command generator: synchronizes raw inputs, debounces btn, and
// issues one registered en strobe with captured data/sel per accepted press.
module bit_cmd_gen #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  input  logic       data_sw,
  input  logic [1:0] sel_sw,
  output logic       en,
  output logic       data,
  output logic [1:0] sel,
  output logic [7:0] cmd_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t                       state;
  logic [CNT_W-1:0]             cnt;
  logic [SYNC_STAGES-1:0]       btn_sync;
  logic [SYNC_STAGES-1:0]       data_sync;
  logic [SYNC_STAGES-1:0][1:0]  sel_sync;

  logic       btn_s;
  logic       data_s;
  logic [1:0] sel_s;
  logic       cnt_done;

  assign btn_s    = btn_sync[SYNC_STAGES-1];
  assign data_s   = data_sync[SYNC_STAGES-1];
  assign sel_s    = sel_sync[SYNC_STAGES-1];
  assign cnt_done = (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_sync  <= '0;
      data_sync <= '0;
      sel_sync  <= '0;
      state     <= IDLE;
      cnt       <= '0;
      en        <= 1'b0;
      data      <= 1'b0;
      sel       <= 2'b00;
      cmd_cnt   <= '0;
    end else begin
      btn_sync  <= {btn_sync[SYNC_STAGES-2:0], btn};
      data_sync <= {data_sync[SYNC_STAGES-2:0], data_sw};
      sel_sync  <= {sel_sync[SYNC_STAGES-2:0], sel_sw};
      en        <= 1'b0;

      case (state)
        IDLE: begin
          cnt <= '0;
          if (btn_s) state <= PRESS_WAIT;
        end
        PRESS_WAIT: begin
          if (!btn_s) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt_done) begin
            // Accepted press: the only path that issues a command.
            state   <= PRESSED;
            cnt     <= '0;
            en      <= 1'b1;
            data    <= data_s;
            sel     <= sel_s;
            cmd_cnt <= cmd_cnt + 8'd1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        PRESSED: begin
          cnt <= '0;
          if (!btn_s) state <= RELEASE_WAIT;
        end
        RELEASE_WAIT: begin
          if (btn_s) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt_done) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bit_cmd_gen.sv
// Directed bench for bit_cmd_gen with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
module tb_bit_cmd_gen;

  localparam int unsigned DEB  = 4;
  localparam int unsigned SYNC = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn;
  logic       data_sw;
  logic [1:0] sel_sw;
  logic       en;
  logic       data;
  logic [1:0] sel;
  logic [7:0] cmd_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bit_cmd_gen #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W(3),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn(btn),
    .data_sw(data_sw),
    .sel_sw(sel_sw),
    .en(en),
    .data(data),
    .sel(sel),
    .cmd_cnt(cmd_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advances n edges; index 0 is the first edge after the call.
  task automatic run(input int n, output int pulses, output int first,
                     output int consec, output logic cd, output logic [1:0] cs);
    logic prev;
    prev = 1'b0; pulses = 0; first = -1; consec = 0; cd = 1'b0; cs = 2'b00;
    for (int i = 0; i < n; i++) begin
      step();
      if (en) begin
        if (prev) consec++;
        pulses++;
        if (first < 0) begin
          first = i; cd = data; cs = sel;
        end
      end
      prev = en;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; btn = 1'b0; data_sw = 1'b0; sel_sw = 2'b00;
    repeat (3) step();
    rst = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_reset();
    int p, f, c; logic cd; logic [1:0] cs;
    rst = 1'b1; btn = 1'b1; data_sw = 1'b1; sel_sw = 2'b11;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if ({en, data, sel, cmd_cnt} !== 12'h000) begin
        fails++;
        $display("FAIL reset_outputs cycle %0d: en=%b data=%b sel=%0d cmd_cnt=%0d expected all 0",
                 i, en, data, sel, cmd_cnt);
      end
    end
    btn = 1'b0;
    step();
    rst = 1'b0;
    run(8, p, f, c, cd, cs);
    tests++;
    if (p !== 0) begin fails++; $display("FAIL reset_idle_pulses: got %0d expected 0", p); end
  endtask

  task automatic test_clean_press();
    int p, f, c; logic cd; logic [1:0] cs;
    do_reset();
    data_sw = 1'b1; sel_sw = 2'b10; btn = 1'b1;
    run(14, p, f, c, cd, cs);
    tests++;
    if (p !== 1) begin fails++; $display("FAIL clean_pulses: got %0d expected 1", p); end
    tests++;
    if (f !== 6) begin fails++; $display("FAIL clean_latency: got %0d expected 6", f); end
    tests++;
    if (c !== 0) begin fails++; $display("FAIL clean_consecutive_en: got %0d expected 0", c); end
    tests++;
    if (cd !== 1'b1) begin fails++; $display("FAIL clean_data: got %b expected 1", cd); end
    tests++;
    if (cs !== 2'd2) begin fails++; $display("FAIL clean_sel: got %0d expected 2", cs); end
    tests++;
    if (cmd_cnt !== 8'd1) begin fails++; $display("FAIL clean_cmd_cnt: got %0d expected 1", cmd_cnt); end
    data_sw = 1'b0; sel_sw = 2'b01;
    run(6, p, f, c, cd, cs);
    tests++;
    if (p !== 0) begin fails++; $display("FAIL hold_pulses: got %0d expected 0", p); end
    tests++;
    if ({data, sel} !== 3'b110) begin
      fails++; $display("FAIL hold_data_sel: got data=%b sel=%0d expected data=1 sel=2", data, sel);
    end
    btn = 1'b0;
    run(10, p, f, c, cd, cs);
  endtask

  task automatic test_bounce();
    logic [5:0] pat;
    int p, f;
    do_reset();
    pat = 6'b101011;  // bit i applied at edge i: 1,1,0,1,0,1
    data_sw = 1'b0; sel_sw = 2'b01;
    p = 0; f = -1;
    for (int i = 0; i < 20; i++) begin
      btn = (i < 6) ? pat[i] : 1'b1;
      step();
      if (en) begin
        p++;
        if (f < 0) f = i;
      end
    end
    tests++;
    if (p !== 1) begin fails++; $display("FAIL bounce_pulses: got %0d expected 1", p); end
    tests++;
    if (f !== 11) begin fails++; $display("FAIL bounce_latency: got edge %0d expected 11", f); end
    tests++;
    if (cmd_cnt !== 8'd1) begin fails++; $display("FAIL bounce_cmd_cnt: got %0d expected 1", cmd_cnt); end
    tests++;
    if ({data, sel} !== 3'b001) begin
      fails++; $display("FAIL bounce_data_sel: got data=%b sel=%0d expected data=0 sel=1", data, sel);
    end
  endtask

  task automatic test_release_bounce();
    int p, f, c; logic cd; logic [1:0] cs;
    do_reset();
    data_sw = 1'b1; sel_sw = 2'b11; btn = 1'b1;
    run(10, p, f, c, cd, cs);
    tests++;
    if (p !== 1) begin fails++; $display("FAIL relb_first_pulses: got %0d expected 1", p); end
    btn = 1'b0;
    run(2, p, f, c, cd, cs);
    btn = 1'b1;
    run(10, p, f, c, cd, cs);
    tests++;
    if (p !== 0) begin fails++; $display("FAIL relb_glitch_pulses: got %0d expected 0", p); end
    tests++;
    if (cmd_cnt !== 8'd1) begin fails++; $display("FAIL relb_glitch_cmd_cnt: got %0d expected 1", cmd_cnt); end
    btn = 1'b0;
    run(10, p, f, c, cd, cs);
    data_sw = 1'b0; sel_sw = 2'b01; btn = 1'b1;
    run(10, p, f, c, cd, cs);
    tests++;
    if (p !== 1 || f !== 6) begin
      fails++; $display("FAIL relb_repress: got pulses=%0d edge=%0d expected pulses=1 edge=6", p, f);
    end
    tests++;
    if (cmd_cnt !== 8'd2) begin fails++; $display("FAIL relb_cmd_cnt: got %0d expected 2", cmd_cnt); end
    tests++;
    if (cd !== 1'b0 || cs !== 2'd1) begin
      fails++; $display("FAIL relb_data_sel: got data=%b sel=%0d expected data=0 sel=1", cd, cs);
    end
  endtask

  task automatic test_reset_mid_debounce();
    int p, f, c; logic cd; logic [1:0] cs;
    do_reset();
    data_sw = 1'b1; sel_sw = 2'b01; btn = 1'b1;
    run(4, p, f, c, cd, cs);
    tests++;
    if (p !== 0) begin fails++; $display("FAIL midrst_pre_pulses: got %0d expected 0", p); end
    rst = 1'b1;
    run(2, p, f, c, cd, cs);
    tests++;
    if (p !== 0 || cmd_cnt !== 8'd0) begin
      fails++; $display("FAIL midrst_in_reset: got pulses=%0d cmd_cnt=%0d expected 0 0", p, cmd_cnt);
    end
    rst = 1'b0;
    run(12, p, f, c, cd, cs);
    tests++;
    if (p !== 1 || f !== 6) begin
      fails++; $display("FAIL midrst_after: got pulses=%0d edge=%0d expected pulses=1 edge=6", p, f);
    end
    tests++;
    if (cmd_cnt !== 8'd1) begin fails++; $display("FAIL midrst_cmd_cnt: got %0d expected 1", cmd_cnt); end
  endtask

  task automatic test_wrap();
    int p, f, c; logic cd; logic [1:0] cs;
    logic       exp_d;
    logic [1:0] exp_s;
    do_reset();
    for (int k = 0; k < 256; k++) begin
      exp_d = 1'(k % 2);
      exp_s = 2'((k + 1) % 4);
      data_sw = exp_d; sel_sw = exp_s; btn = 1'b1;
      run(8, p, f, c, cd, cs);
      tests++;
      if (p !== 1 || cd !== exp_d || cs !== exp_s) begin
        fails++;
        $display("FAIL wrap_press %0d: got pulses=%0d data=%b sel=%0d expected 1 %b %0d",
                 k, p, cd, cs, exp_d, exp_s);
      end
      tests++;
      if (cmd_cnt !== 8'((k + 1) % 256)) begin
        fails++; $display("FAIL wrap_cmd_cnt %0d: got %0d expected %0d", k, cmd_cnt, (k + 1) % 256);
      end
      btn = 1'b0;
      run(8, p, f, c, cd, cs);
    end
    tests++;
    if (cmd_cnt !== 8'd0) begin fails++; $display("FAIL wrap_final: got %0d expected 0", cmd_cnt); end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_bounce();
    test_reset_mid_debounce();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
